// File: rtl/kv_pkg.sv
// Shared widths and types for the key-value store datapath.
// Used by the hash generator and the table controller.
package kv_pkg;

    localparam int unsigned KEY_W              = 32;
    localparam int unsigned HASH_W             = 32;
    localparam int unsigned DEFAULT_TABLE_SIZE = 11;

    typedef logic [KEY_W-1:0]  key_t;
    typedef logic [HASH_W-1:0] hash_t;

endpackage

// File: rtl/hash_divmod.sv
// Combinational unsigned divide/modulo of a 32-bit value by a constant.
// The divisor is fixed at elaboration, so synthesis reduces it to constant logic.
module hash_divmod
    import kv_pkg::*;
#(
    parameter int unsigned DIVISOR = DEFAULT_TABLE_SIZE
) (
    input  logic [KEY_W-1:0] i_dividend,
    output logic [KEY_W-1:0] o_quot,
    output logic [KEY_W-1:0] o_rem
);

    localparam logic [KEY_W-1:0] W_DIV = KEY_W'(DIVISOR);

    always_comb begin
        o_quot = i_dividend / W_DIV;
        o_rem  = i_dividend % W_DIV;
    end

endmodule

// File: rtl/hash_func.sv
// Cuckoo-table dual index generator: primary and alternate bucket for each key.
// One register stage after a constant divide/modulo chain; outputs come only from flops.
module hash_func
    import kv_pkg::*;
#(
    parameter int unsigned TABLE_SIZE = DEFAULT_TABLE_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key,
    output logic [HASH_W-1:0] hash1,
    output logic [HASH_W-1:0] hash2,
    output logic              hash_valid
);

    generate
        if (TABLE_SIZE < 2 || TABLE_SIZE > 65535) begin : g_bad_table_size
            $error("hash_func: TABLE_SIZE must lie in 2..65535");
        end
    endgenerate

    key_t  w_q1;
    key_t  w_rem1;
    key_t  w_rem2;
    key_t  w_q2_unused;

    hash_t r_hash1_p1;
    hash_t r_hash2_p1;
    logic  r_vld_p1;

    // Second stage divides the first quotient, giving an index independent of hash1.
    hash_divmod #(.DIVISOR(TABLE_SIZE)) u_div_key (
        .i_dividend (key),
        .o_quot     (w_q1),
        .o_rem      (w_rem1)
    );

    hash_divmod #(.DIVISOR(TABLE_SIZE)) u_div_quot (
        .i_dividend (w_q1),
        .o_quot     (w_q2_unused),
        .o_rem      (w_rem2)
    );

    // p0 -> p1: indices load on accepted keys and hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hash1_p1 <= '0;
            r_hash2_p1 <= '0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= key_valid;
            if (key_valid) begin
                r_hash1_p1 <= w_rem1;
                r_hash2_p1 <= w_rem2;
            end
        end
    end

    assign hash1      = r_hash1_p1;
    assign hash2      = r_hash2_p1;
    assign hash_valid = r_vld_p1;

endmodule

// File: tb/tb_hash_func.sv
// Directed and swept check of hash_func for TABLE_SIZE 11 (default) and 16.
module tb_hash_func;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [31:0] key;
    logic [31:0] hash1, hash2;
    logic        hash_valid;
    logic [31:0] hash1_16, hash2_16;
    logic        hash_valid_16;

    int n_assert = 0;
    int n_fail   = 0;

    hash_func dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key        (key),
        .hash1      (hash1),
        .hash2      (hash2),
        .hash_valid (hash_valid)
    );

    hash_func #(.TABLE_SIZE(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key        (key),
        .hash1      (hash1_16),
        .hash2      (hash2_16),
        .hash_valid (hash_valid_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic v, input logic [31:0] k);
        key_valid = v;
        key       = k;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic ev);
        chk({tag, ".hash1"}, hash1, e1);
        chk({tag, ".hash2"}, hash2, e2);
        chk({tag, ".valid"}, {31'd0, hash_valid}, {31'd0, ev});
    endtask

    initial begin
        logic [31:0] k;

        rst_n     = 1'b0;
        key_valid = 1'b1;
        key       = 32'd296;
        @(posedge clk); #1;
        apply(1'b1, 32'd82);
        chk_out("reset", 32'd0, 32'd0, 1'b0);
        chk("reset16.hash1", hash1_16, 32'd0);
        chk("reset16.valid", {31'd0, hash_valid_16}, 32'd0);
        rst_n = 1'b1;

        apply(1'b1, 32'd16);  chk_out("k16",  32'd5,  32'd1, 1'b1);
        apply(1'b1, 32'd44);  chk_out("k44",  32'd0,  32'd4, 1'b1);
        apply(1'b1, 32'd82);  chk_out("k82",  32'd5,  32'd7, 1'b1);
        apply(1'b1, 32'd296); chk_out("k296", 32'd10, 32'd4, 1'b1);
        apply(1'b1, 32'd777); chk_out("k777", 32'd7,  32'd4, 1'b1);
        apply(1'b1, 32'd892); chk_out("k892", 32'd1,  32'd4, 1'b1);
        apply(1'b1, 32'd0);   chk_out("k0",   32'd0,  32'd0, 1'b1);
        apply(1'b1, 32'd10);  chk_out("k10",  32'd10, 32'd0, 1'b1);
        apply(1'b1, 32'hFFFF_FFFF); chk_out("kmax", 32'd3, 32'd5, 1'b1);

        apply(1'b1, 32'd100); chk_out("k100", 32'd1, 32'd9, 1'b1);
        apply(1'b0, 32'd555); chk_out("hold1", 32'd1, 32'd9, 1'b0);
        apply(1'b0, 32'd17);  chk_out("hold2", 32'd1, 32'd9, 1'b0);
        apply(1'b0, 32'd0);   chk_out("hold3", 32'd1, 32'd9, 1'b0);

        apply(1'b1, 32'd16);  chk_out("pre_rst", 32'd5, 32'd1, 1'b1);
        rst_n = 1'b0;
        apply(1'b1, 32'd44);  chk_out("mid_rst", 32'd0, 32'd0, 1'b0);
        rst_n = 1'b1;
        apply(1'b1, 32'd82);  chk_out("post_rst", 32'd5, 32'd7, 1'b1);
        apply(1'b1, 32'd296); chk_out("post_rst2", 32'd10, 32'd4, 1'b1);

        apply(1'b1, 32'h1234_5678);
        chk("ts16.hash1", hash1_16, 32'd8);
        chk("ts16.hash2", hash2_16, 32'd7);
        chk("ts16.valid", {31'd0, hash_valid_16}, 32'd1);
        apply(1'b1, 32'hFFFF_FFFF);
        chk("ts16max.hash1", hash1_16, 32'd15);
        chk("ts16max.hash2", hash2_16, 32'd15);

        for (int i = 0; i < 10000; i++) begin
            k = $urandom;
            apply(1'b1, k);
            chk("sweep11.hash1", hash1, k % 32'd11);
            chk("sweep11.hash2", hash2, (k / 32'd11) % 32'd11);
            chk("sweep16.hash1", hash1_16, k % 32'd16);
            chk("sweep16.hash2", hash2_16, (k / 32'd16) % 32'd16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
